complex_accum: RTL and testbench
================================

# complex_accum

Downstream stage of the complex multiplier. Accepts a stream of signed 16-bit complex products, sums `N` consecutive accepted samples per frame, then computes the frame's power |sum|² with one shared multiplier over two cycles. It presents the sum and the power with a one-cycle `out_valid` strobe. This is the dot-product / correlation back end.

## Interface
Parameters:
- `DATA_W`, 16, width of each input component (signed).
- `N`, 8, samples per frame; power of two, 2..256.
- `ACC_W`, `DATA_W+$clog2(N)`, accumulator width (signed, derived, not overridden).
- `POW_W`, `2*ACC_W`, power output width (unsigned, derived).

Ports:
- `clk`, in, 1, clock; all logic on rising edge.
- `rst`, in, 1, reset; synchronous, active-high.
- `in_valid`, in, 1, input sample present.
- `in_ready`, out, 1, block can take a sample; a sample is accepted when `in_valid && in_ready`.
- `in_real`, in, `DATA_W`, signed real part.
- `in_imag`, in, `DATA_W`, signed imaginary part.
- `frame_abort`, in, 1, discard the partial frame.
- `out_valid`, out, 1, one-cycle strobe; results are new.
- `out_real`, out, `ACC_W`, signed frame sum, real part.
- `out_imag`, out, `ACC_W`, signed frame sum, imaginary part.
- `out_power`, out, `POW_W`, unsigned `out_real²+out_imag²`.
- `frame_cnt`, out, 8, count of completed frames, wraps 255→0.

## Operation
- The FSM has three states, `ACC`, `SQ_RE` and `SQ_IM`. Reset state is `ACC`.
- `in_ready` is 1 only in `ACC`.
- **`ACC` state:**
  - On accept, the sample is sign-extended to `ACC_W` and added to the accumulators, and `sample_cnt` is incremented.
  - On accept of sample `N` (`sample_cnt==N-1`): the final sums are latched, the accumulators and `sample_cnt` clear, and the FSM goes to `SQ_RE`.
- **`SQ_RE` state:** `sq_reg <= sum_re*sum_re` (unsigned `POW_W`), then go to `SQ_IM`.
- **`SQ_IM` state:**
  - `out_power <= sq_reg + sum_im*sum_im`.
  - `out_real`/`out_imag` take the latched sums.
  - `out_valid <= 1` and `frame_cnt++`.
  - Go to `ACC`.
- **Multiplier:** one signed `ACC_W`×`ACC_W` multiplier, time-shared. There are no other multipliers.
- **Width rule:** `ACC_W` guarantees no accumulator overflow, so the block does no saturation. The maximum power is 2·(2^(ACC_W-1))², which fits `POW_W` unsigned.
- **Output hold:** outputs hold their values until the next `SQ_IM`. `out_valid` is 0 at every other time.
- **`frame_abort` in `ACC`:**
  - Clears the accumulators and `sample_cnt`.
  - A sample offered in the same cycle is not accepted. `in_ready` stays 1, but abort wins and the sample is dropped.
- **`frame_abort` in `SQ_RE`/`SQ_IM`:** ignored; the completed frame is still reported.
- **`in_valid` while `in_ready=0`:** the sample is not accepted. The upstream producer must hold it.
- **Reset values:**
  - `out_valid=0`, `out_real=0`, `out_imag=0`, `out_power=0`, `frame_cnt=0`, `in_ready=1`.
  - Accumulators, `sample_cnt` and `sq_reg` are 0.
- **Reset mid-frame or in `SQ_*`:** the partial or in-flight frame is lost, with no `out_valid`.

## Timing
- **Result latency:** sample `N` is accepted on edge t. `out_valid` is high in the cycle after edge t+2, i.e. 3 cycles after the accept cycle.
- **Stall:** `in_ready` is low for exactly 2 cycles per frame (`SQ_RE`, `SQ_IM`).
- **Back-to-back streaming:** `in_ready` returns to 1 in the same cycle `out_valid` is high. That cycle can accept sample 1 of the next frame.
- **Throughput:** N samples per N+2 cycles.
- **`frame_cnt`** updates on the same edge as `out_valid` rises.

## Structure
- Package `complex_pkg` holds:
  - the state enum `cacc_state_t` {`ACC`, `SQ_RE`, `SQ_IM`};
  - the default `DATA_W`/`N` localparams;
  - a width helper function for `ACC_W`/`POW_W`.
- One sub-module, `complex_sq_unit`. It holds the shared multiplier, `sq_reg` and the final adder, and takes an operand-select input from the FSM.
- The top-level holds the FSM, the accumulators, the counters and the output registers.

## Test plan
- **Basic frame:** `rst` for 2 cycles, then 8 consecutive samples (1000, −500). Expect `out_real`=8000, `out_imag`=−4000, `out_power`=80,000,000, `out_valid` 3 cycles after the last accept, `frame_cnt`=1.
- **Extreme values:** 8 samples (−32768, −32768). Expect sums −262144 each and `out_power`=137,438,953,472 (2^37). Checks no overflow and no sign error.
- **Back-to-back with stall:** `in_valid` held high for 30 cycles with an incrementing real part 1,2,3… and imag 0. Expect `in_ready` low for exactly 2 cycles after every 8th accept, frame sums 36 and 100, and no sample lost or duplicated.
- **Abort:**
  - 5 samples (10, 10), then `frame_abort` asserted together with `in_valid`, then 8 samples (1, −1).
  - Expect one result: (8, −8), power 128.
  - Abort asserted during `SQ_RE` must not suppress that frame's result.
- **Reset mid-operation:**
  - Assert `rst` one cycle after sample 8 is accepted. Expect no `out_valid` and all outputs 0.
  - A fresh frame afterwards reports correctly and `frame_cnt`=1.
- **Gapped input:** 8 samples (3, 4) with random `in_valid` gaps. Expect sum (24, 32) and power 1600.

Source files
------------

// File: rtl/complex_pkg.sv
// Shared types, default sizes and width helpers for the complex accumulator.
package complex_pkg;

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    SQ_RE = 2'd1,
    SQ_IM = 2'd2
  } cacc_state_t;

  localparam int DATA_W_DEF = 16;
  localparam int N_DEF      = 8;

  // Accumulator grows by log2(N) bits so N full-scale samples cannot overflow.
  function automatic int acc_width(input int data_w, input int n);
    return data_w + $clog2(n);
  endfunction

  // A square of an ACC_W signed value, plus a second such square, fits 2*ACC_W unsigned.
  function automatic int pow_width(input int data_w, input int n);
    return 2 * acc_width(data_w, n);
  endfunction

endpackage

// File: rtl/complex_sq_unit.sv
// Time-shared squarer: one signed multiplier, the partial-square register
// and the final adder that forms re^2 + im^2.
module complex_sq_unit
  import complex_pkg::*;
#(
  parameter int ACC_W = 19,
  parameter int POW_W = 2 * ACC_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sel_im_i,
  input  logic                    load_sq_i,
  input  logic signed [ACC_W-1:0] sum_re_i,
  input  logic signed [ACC_W-1:0] sum_im_i,
  output logic        [POW_W-1:0] power_o
);

  logic signed [ACC_W-1:0] op;
  logic signed [POW_W-1:0] op_ext;
  logic signed [POW_W-1:0] prod;
  logic        [POW_W-1:0] sq_q;
  logic        [POW_W-1:0] sq_d;

  assign op     = sel_im_i ? sum_im_i : sum_re_i;
  // Operand widened before the multiply so the full square is kept.
  assign op_ext = {{(POW_W-ACC_W){op[ACC_W-1]}}, op};
  assign prod   = op_ext * op_ext;

  // A square is never negative, so the signed product reinterprets as unsigned.
  assign sq_d    = load_sq_i ? prod : sq_q;
  assign power_o = sq_q + prod;

  // Hold re^2 from the SQ_RE cycle for the adder in SQ_IM.
  always_ff @(posedge clk) begin
    if (rst) sq_q <= '0;
    else     sq_q <= sq_d;
  end

endmodule

// File: rtl/complex_accum.sv
// Frame accumulator for complex products: sums N accepted samples, then
// reports the sum and its power |sum|^2 with a one-cycle strobe.
//
//   state | meaning
//   ACC   | accepting samples, accumulating the current frame
//   SQ_RE | squaring the latched real sum into the partial register
//   SQ_IM | adding the imaginary square, publishing results
module complex_accum
  import complex_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int N      = N_DEF,
  localparam int ACC_W  = acc_width(DATA_W, N),
  localparam int POW_W  = pow_width(DATA_W, N)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_real,
  input  logic signed [DATA_W-1:0] in_imag,
  input  logic                     frame_abort,
  output logic                     out_valid,
  output logic signed [ACC_W-1:0]  out_real,
  output logic signed [ACC_W-1:0]  out_imag,
  output logic        [POW_W-1:0]  out_power,
  output logic        [7:0]        frame_cnt
);

  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  cacc_state_t state_q, state_d;

  logic signed [ACC_W-1:0] acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic signed [ACC_W-1:0] sum_re_q, sum_re_d, sum_im_q, sum_im_d;
  logic        [CNT_W-1:0] sample_cnt_q, sample_cnt_d;

  logic                    out_valid_q, out_valid_d;
  logic signed [ACC_W-1:0] out_real_q, out_real_d, out_imag_q, out_imag_d;
  logic        [POW_W-1:0] out_power_q, out_power_d;
  logic        [7:0]       frame_cnt_q, frame_cnt_d;

  logic signed [ACC_W-1:0] ext_re, ext_im, next_re, next_im;
  logic        [POW_W-1:0] power_sum;

  assign ext_re  = {{(ACC_W-DATA_W){in_real[DATA_W-1]}}, in_real};
  assign ext_im  = {{(ACC_W-DATA_W){in_imag[DATA_W-1]}}, in_imag};
  assign next_re = acc_re_q + ext_re;
  assign next_im = acc_im_q + ext_im;

  assign in_ready = (state_q == ACC);

  complex_sq_unit #(
    .ACC_W (ACC_W),
    .POW_W (POW_W)
  ) u_sq (
    .clk       (clk),
    .rst       (rst),
    .sel_im_i  (state_q == SQ_IM),
    .load_sq_i (state_q == SQ_RE),
    .sum_re_i  (sum_re_q),
    .sum_im_i  (sum_im_q),
    .power_o   (power_sum)
  );

  // Next-state, accumulation and result publishing.
  always_comb begin
    state_d      = state_q;
    acc_re_d     = acc_re_q;
    acc_im_d     = acc_im_q;
    sum_re_d     = sum_re_q;
    sum_im_d     = sum_im_q;
    sample_cnt_d = sample_cnt_q;
    out_valid_d  = 1'b0;
    out_real_d   = out_real_q;
    out_imag_d   = out_imag_q;
    out_power_d  = out_power_q;
    frame_cnt_d  = frame_cnt_q;

    case (state_q)
      ACC: begin
        // Abort takes priority over a sample offered in the same cycle.
        if (frame_abort) begin
          acc_re_d     = '0;
          acc_im_d     = '0;
          sample_cnt_d = '0;
        end else if (in_valid) begin
          if (sample_cnt_q == LAST) begin
            sum_re_d     = next_re;
            sum_im_d     = next_im;
            acc_re_d     = '0;
            acc_im_d     = '0;
            sample_cnt_d = '0;
            state_d      = SQ_RE;
          end else begin
            acc_re_d     = next_re;
            acc_im_d     = next_im;
            sample_cnt_d = sample_cnt_q + CNT_W'(1);
          end
        end
      end
      SQ_RE: state_d = SQ_IM;
      SQ_IM: begin
        out_valid_d = 1'b1;
        out_real_d  = sum_re_q;
        out_imag_d  = sum_im_q;
        out_power_d = power_sum;
        frame_cnt_d = frame_cnt_q + 8'd1;
        state_d     = ACC;
      end
      default: state_d = ACC;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ACC;
      acc_re_q     <= '0;
      acc_im_q     <= '0;
      sum_re_q     <= '0;
      sum_im_q     <= '0;
      sample_cnt_q <= '0;
      out_valid_q  <= 1'b0;
      out_real_q   <= '0;
      out_imag_q   <= '0;
      out_power_q  <= '0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      acc_re_q     <= acc_re_d;
      acc_im_q     <= acc_im_d;
      sum_re_q     <= sum_re_d;
      sum_im_q     <= sum_im_d;
      sample_cnt_q <= sample_cnt_d;
      out_valid_q  <= out_valid_d;
      out_real_q   <= out_real_d;
      out_imag_q   <= out_imag_d;
      out_power_q  <= out_power_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_real  = out_real_q;
  assign out_imag  = out_imag_q;
  assign out_power = out_power_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_complex_accum.sv
// Bench for complex_accum: a cycle model predicts ready/valid and pushes
// expected frame results into a scoreboard queue that the monitor pops.
module tb_complex_accum;

  localparam int DATA_W = 16;
  localparam int N      = 8;
  localparam int ACC_W  = 19;
  localparam int POW_W  = 38;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_real = '0;
  logic signed [DATA_W-1:0] in_imag = '0;
  logic                     frame_abort = 1'b0;
  logic                     out_valid;
  logic signed [ACC_W-1:0]  out_real;
  logic signed [ACC_W-1:0]  out_imag;
  logic        [POW_W-1:0]  out_power;
  logic        [7:0]        frame_cnt;

  complex_accum dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_real     (in_real),
    .in_imag     (in_imag),
    .frame_abort (frame_abort),
    .out_valid   (out_valid),
    .out_real    (out_real),
    .out_imag    (out_imag),
    .out_power   (out_power),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint re;
    longint im;
    longint pw;
    longint fc;
  } res_t;

  res_t sbq[$];
  res_t got[$];

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Cycle model of the block.
  int     m_state = 0;
  int     m_cnt   = 0;
  longint m_re    = 0;
  longint m_im    = 0;
  longint m_fcnt  = 0;
  bit     m_valid = 1'b0;
  bit     acc_flag = 1'b0;
  int     n_acc   = 0;
  longint h_re = 0, h_im = 0, h_pw = 0, h_fc = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check outputs against the model, then advance the model across the coming edge.
  always @(negedge clk) begin
    res_t e;
    if (chk_en) begin
      chk("in_ready", 64'(in_ready), 64'(m_state == 0));
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      if (out_valid === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("unexpected_result", 64'(1), 64'(0));
        end else begin
          e = sbq.pop_front();
          chk("out_real", out_real, e.re);
          chk("out_imag", out_imag, e.im);
          chk("out_power", $signed({26'd0, out_power}), e.pw);
          chk("frame_cnt", $signed({56'd0, frame_cnt}), e.fc);
          got.push_back('{re: longint'(out_real), im: longint'(out_imag),
                          pw: longint'(out_power), fc: longint'(frame_cnt)});
          h_re = e.re; h_im = e.im; h_pw = e.pw; h_fc = e.fc;
        end
      end else begin
        chk("hold_real", out_real, h_re);
        chk("hold_imag", out_imag, h_im);
        chk("hold_power", $signed({26'd0, out_power}), h_pw);
        chk("hold_fcnt", $signed({56'd0, frame_cnt}), h_fc);
      end
    end

    acc_flag = 1'b0;
    if (rst) begin
      m_state = 0; m_cnt = 0; m_re = 0; m_im = 0; m_fcnt = 0; m_valid = 1'b0;
      h_re = 0; h_im = 0; h_pw = 0; h_fc = 0;
      sbq.delete();
    end else begin
      m_valid = 1'b0;
      case (m_state)
        0: begin
          if (frame_abort) begin
            m_re = 0; m_im = 0; m_cnt = 0;
          end else if (in_valid) begin
            acc_flag = 1'b1;
            n_acc++;
            m_re += longint'(in_real);
            m_im += longint'(in_imag);
            if (m_cnt == N - 1) begin
              sbq.push_back('{re: m_re, im: m_im, pw: m_re * m_re + m_im * m_im,
                              fc: (m_fcnt + 1) % 256});
              m_re = 0; m_im = 0; m_cnt = 0; m_state = 1;
            end else begin
              m_cnt++;
            end
          end
        end
        1: m_state = 2;
        default: begin
          m_state = 0;
          m_valid = 1'b1;
          m_fcnt  = (m_fcnt + 1) % 256;
        end
      endcase
    end
  end

  // Offer one sample and hold it until the model sees it accepted.
  task automatic send(input int re, input int im);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_real  = DATA_W'(re);
    in_imag  = DATA_W'(im);
    for (int k = 0; k < 20 && !done; k++) begin
      tick();
      if (acc_flag) done = 1'b1;
    end
    if (!done) chk("accept_timeout", 64'(0), 64'(1));
    in_valid = 1'b0;
  endtask

  initial begin
    int base;
    int val;

    // Reset for two cycles and check reset values.
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_real", out_real, 0);
    chk("rst_out_power", $signed({26'd0, out_power}), 0);
    chk("rst_frame_cnt", $signed({56'd0, frame_cnt}), 0);
    chk_en = 1'b1;

    // Basic frame with result latency check.
    for (int i = 0; i < N; i++) send(1000, -500);
    base = got.size();
    tick();
    chk("lat_1", 64'(out_valid), 64'(0));
    tick();
    chk("lat_3", 64'(out_valid), 64'(1));
    repeat (3) tick();
    chk("basic_count", got.size(), base + 1);
    if (got.size() > base) begin
      chk("basic_re", got[base].re, 8000);
      chk("basic_im", got[base].im, -4000);
      chk("basic_pw", got[base].pw, 80000000);
      chk("basic_fc", got[base].fc, 1);
    end

    // Extreme negative full scale.
    base = got.size();
    for (int i = 0; i < N; i++) send(-32768, -32768);
    repeat (5) tick();
    chk("ext_count", got.size(), base + 1);
    if (got.size() > base) begin
      chk("ext_re", got[base].re, -262144);
      chk("ext_im", got[base].im, -262144);
      chk("ext_pw", got[base].pw, 64'd137438953472);
    end

    // Streaming with in_valid held high for 30 cycles.
    base = got.size();
    n_acc = 0;
    val = 1;
    in_valid = 1'b1;
    in_imag  = '0;
    for (int c = 0; c < 30; c++) begin
      in_real = DATA_W'(val);
      tick();
      if (acc_flag) val++;
    end
    in_valid = 1'b0;
    repeat (5) tick();
    chk("stream_accepts", n_acc, 24);
    chk("stream_count", got.size(), base + 3);
    if (got.size() > base + 2) begin
      chk("stream_f1", got[base].re, 36);
      chk("stream_f2", got[base + 1].re, 100);
      chk("stream_f3", got[base + 2].re, 164);
      chk("stream_f2_im", got[base + 1].im, 0);
    end

    // Abort with a sample offered in the same cycle, then a clean frame.
    base = got.size();
    for (int i = 0; i < 5; i++) send(10, 10);
    in_valid    = 1'b1;
    in_real     = 16'sd10;
    in_imag     = 16'sd10;
    frame_abort = 1'b1;
    tick();
    frame_abort = 1'b0;
    in_valid    = 1'b0;
    for (int i = 0; i < N; i++) send(1, -1);
    // Now in SQ_RE: an abort here must not suppress the result.
    frame_abort = 1'b1;
    tick();
    frame_abort = 1'b0;
    repeat (4) tick();
    chk("abort_count", got.size(), base + 1);
    if (got.size() > base) begin
      chk("abort_re", got[base].re, 8);
      chk("abort_im", got[base].im, -8);
      chk("abort_pw", got[base].pw, 128);
    end

    // Reset one cycle after the last accept: the frame is lost.
    base = got.size();
    for (int i = 0; i < N; i++) send(7, 7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("rstmid_count", got.size(), base);
    chk("rstmid_real", out_real, 0);
    chk("rstmid_power", $signed({26'd0, out_power}), 0);
    chk("rstmid_fcnt", $signed({56'd0, frame_cnt}), 0);
    for (int i = 0; i < N; i++) send(2, 3);
    repeat (4) tick();
    chk("fresh_count", got.size(), base + 1);
    if (got.size() > base) begin
      chk("fresh_re", got[base].re, 16);
      chk("fresh_pw", got[base].pw, 16 * 16 + 24 * 24);
      chk("fresh_fc", got[base].fc, 1);
    end

    // Gapped input.
    base = got.size();
    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      send(3, 4);
    end
    repeat (5) tick();
    chk("gap_count", got.size(), base + 1);
    if (got.size() > base) begin
      chk("gap_re", got[base].re, 24);
      chk("gap_im", got[base].im, 32);
      chk("gap_pw", got[base].pw, 1600);
    end
    chk("sb_empty", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
